// File: rtl/pipeline_exec_controller.sv
// pipeline_exec_controller: run/step/halt sequencer gating fetch and the downstream pipeline registers.
module pipeline_exec_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  output logic                 cmd_ready,
  input  logic                 halt_id,
  output logic                 fetch_en,
  output logic                 pipe_en,
  output logic                 halted,
  output logic                 step_done,
  output logic [CNT_WIDTH-1:0] cycle_count
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  state_t               state_q, state_d;
  logic [3:0]           drain_q, drain_d;
  logic                 step_done_q, step_done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  assign cmd_ready   = !reset && (state_q == IDLE || state_q == RUN || state_q == HALTED);
  assign pipe_en     = !reset && (state_q == RUN || state_q == STEP || state_q == DRAIN);
  assign fetch_en    = !reset && (state_q == RUN || state_q == STEP) && !halt_id;
  assign halted      = state_q == HALTED;
  assign step_done   = step_done_q;
  assign cycle_count = cnt_q;
  assign accept      = cmd_valid && cmd_ready;
  assign cnt_d       = (pipe_en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    step_done_d = 1'b0;
    case (state_q)
      IDLE: state_d = (accept && cmd == CMD_RUN) ? RUN : (accept && cmd == CMD_STEP) ? STEP : IDLE;
      // halt_id wins over a simultaneous STOP so older instructions still drain
      RUN: begin
        if (halt_id) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (accept && cmd == CMD_STOP) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (halt_id) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d     = IDLE;
          step_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) state_d = HALTED;
        else drain_d = drain_q - 4'd1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= 4'd0;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      step_done_q <= step_done_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_exec_controller.sv
// tb_pipeline_exec_controller: vector table with scoreboard queue; second instance checks DRAIN_CYCLES=1 and counter saturation.
module tb_pipeline_exec_controller;
  logic        clk = 1'b0;
  logic        reset, cmd_valid, halt_id;
  logic [1:0]  cmd;
  logic        cmd_ready, fetch_en, pipe_en, halted, step_done;
  logic [31:0] cycle_count;
  logic        cmd_ready1, fetch_en1, pipe_en1, halted1, step_done1;
  logic [3:0]  cycle_count1;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic rst, v;
    logic [1:0] c;
    logic h, ef, ep, er, eh, es, eh1;
    int cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  pipeline_exec_controller #(.DRAIN_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .halt_id(halt_id), .fetch_en(fetch_en), .pipe_en(pipe_en), .halted(halted),
    .step_done(step_done), .cycle_count(cycle_count));

  pipeline_exec_controller #(.DRAIN_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready1),
    .halt_id(halt_id), .fetch_en(fetch_en1), .pipe_en(pipe_en1), .halted(halted1),
    .step_done(step_done1), .cycle_count(cycle_count1));

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  task automatic add(input logic rst, v, input logic [1:0] c, input logic h,
                     input logic ef, ep, er, eh, es, input int cnt, input logic eh1);
    vec_t x;
    x.rst = rst; x.v = v; x.c = c; x.h = h;
    x.ef = ef; x.ep = ep; x.er = er; x.eh = eh; x.es = es; x.cnt = cnt; x.eh1 = eh1;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic rst, v, input logic [1:0] c, input logic h);
    @(posedge clk);
    #1;
    reset = rst; cmd_valid = v; cmd = c; halt_id = h;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; halt_id = 1'b0;
    // RUN then HALT on 11th RUN cycle, commands while HALTED
    add(1,0,0,0, 0,0,0,0,0, 0,0);
    add(0,1,1,0, 0,0,1,0,0, 0,0);
    for (int i = 0; i < 10; i++) add(0,0,0,0, 1,1,1,0,0, i,0);
    add(0,0,0,1, 0,1,1,0,0, 10,0);
    add(0,0,0,1, 0,1,0,0,0, 11,0);
    add(0,0,0,0, 0,1,0,0,0, 12,1);
    add(0,0,0,0, 0,1,0,0,0, 13,1);
    add(0,0,0,0, 0,1,0,0,0, 14,1);
    add(0,1,1,0, 0,0,1,1,0, 15,1);
    add(0,1,2,0, 0,0,1,1,0, 15,1);
    add(0,0,0,0, 0,0,1,1,0, 15,1);
    // three STEPs spaced 3 cycles apart
    add(1,0,0,0, 0,0,0,1,0, 15,1);
    add(0,1,2,0, 0,0,1,0,0, 0,0);
    add(0,0,0,0, 1,1,0,0,0, 0,0);
    add(0,0,0,0, 0,0,1,0,1, 1,0);
    add(0,1,2,0, 0,0,1,0,0, 1,0);
    add(0,1,1,0, 1,1,0,0,0, 1,0);
    add(0,0,0,0, 0,0,1,0,1, 2,0);
    add(0,1,2,0, 0,0,1,0,0, 2,0);
    add(0,0,0,0, 1,1,0,0,0, 2,0);
    add(0,0,0,0, 0,0,1,0,1, 3,0);
    add(0,0,0,0, 0,0,1,0,0, 3,0);
    // RUN, STOP on 6th cycle, RUN 4 more
    add(1,0,0,0, 0,0,0,0,0, 3,0);
    add(0,1,1,0, 0,0,1,0,0, 0,0);
    add(0,0,0,0, 1,1,1,0,0, 0,0);
    add(0,1,2,0, 1,1,1,0,0, 1,0);
    add(0,0,0,0, 1,1,1,0,0, 2,0);
    add(0,0,0,0, 1,1,1,0,0, 3,0);
    add(0,0,0,0, 1,1,1,0,0, 4,0);
    add(0,1,3,0, 1,1,1,0,0, 5,0);
    add(0,1,1,0, 0,0,1,0,0, 6,0);
    add(0,0,0,0, 1,1,1,0,0, 6,0);
    add(0,0,0,0, 1,1,1,0,0, 7,0);
    add(0,0,0,0, 1,1,1,0,0, 8,0);
    add(0,1,3,0, 1,1,1,0,0, 9,0);
    add(0,0,0,0, 0,0,1,0,0, 10,0);
    // halt_id together with STOP
    add(0,1,1,0, 0,0,1,0,0, 10,0);
    add(0,0,0,0, 1,1,1,0,0, 10,0);
    add(0,1,3,1, 0,1,1,0,0, 11,0);
    add(0,0,0,0, 0,1,0,0,0, 12,0);
    add(0,0,0,0, 0,1,0,0,0, 13,1);
    add(0,0,0,0, 0,1,0,0,0, 14,1);
    add(0,0,0,0, 0,1,0,0,0, 15,1);
    add(0,0,0,0, 0,0,1,1,0, 16,1);
    // reset during 2nd DRAIN cycle, then restart
    add(1,0,0,0, 0,0,0,1,0, 16,1);
    add(0,1,1,0, 0,0,1,0,0, 0,0);
    add(0,0,0,1, 0,1,1,0,0, 0,0);
    add(0,0,0,0, 0,1,0,0,0, 1,0);
    add(1,0,0,0, 0,0,0,0,0, 2,1);
    add(0,1,1,0, 0,0,1,0,0, 0,0);
    add(0,0,0,0, 1,1,1,0,0, 0,0);
    add(0,1,3,0, 1,1,1,0,0, 1,0);
    add(0,0,0,0, 0,0,1,0,0, 2,0);
    // STEP hitting HALT: drain, no step_done
    add(0,1,2,0, 0,0,1,0,0, 2,0);
    add(0,0,0,1, 0,1,0,0,0, 2,0);
    add(0,0,0,0, 0,1,0,0,0, 3,0);
    add(0,0,0,0, 0,1,0,0,0, 4,1);
    add(0,0,0,0, 0,1,0,0,0, 5,1);
    add(0,0,0,0, 0,1,0,0,0, 6,1);
    add(0,0,0,0, 0,0,1,1,0, 7,1);

    drive(1,0,0,0);
    drive(1,0,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      drive(tbl[i].rst, tbl[i].v, tbl[i].c, tbl[i].h);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d fetch_en", i), 32'(fetch_en), 32'(e.ef));
      chk($sformatf("row%0d pipe_en", i), 32'(pipe_en), 32'(e.ep));
      chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(e.er));
      chk($sformatf("row%0d halted", i), 32'(halted), 32'(e.eh));
      chk($sformatf("row%0d step_done", i), 32'(step_done), 32'(e.es));
      chk($sformatf("row%0d cycle_count", i), cycle_count, 32'(e.cnt));
      chk($sformatf("row%0d halted_d1", i), 32'(halted1), 32'(e.eh1));
    end

    // saturation of the 4-bit counter over a 21-cycle run
    drive(1,0,0,0);
    drive(0,1,1,0);
    for (int i = 0; i < 20; i++) drive(0,0,0,0);
    drive(0,1,3,0);
    drive(0,0,0,0);
    @(negedge clk);
    chk("sat cycle_count32", cycle_count, 32'd21);
    chk("sat cycle_count4", 32'(cycle_count1), 32'd15);
    chk("sat pipe_en_off", 32'(pipe_en1), 32'd0);
    chk("sat halted", 32'(halted1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
